// File: rtl/dut_txn_pkg.sv
// Shared definitions for the dut transaction master: dut register map, FSM state
// encoding and the completed-transaction counter width.
package dut_txn_pkg;

    localparam logic [2:0] ADDR_A_ST = 3'd0;
    localparam logic [2:0] ADDR_B_ST = 3'd1;
    localparam logic [2:0] ADDR_Y_ST = 3'd2;
    localparam logic [2:0] ADDR_Y    = 3'd3;
    localparam logic [2:0] ADDR_A    = 3'd4;
    localparam logic [2:0] ADDR_B    = 3'd5;

    localparam int TXN_CNT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHK_A = 3'd1,
        ST_WR_A  = 3'd2,
        ST_CHK_B = 3'd3,
        ST_WR_B  = 3'd4,
        ST_CHK_Y = 3'd5,
        ST_RD_Y  = 3'd6,
        ST_OUT   = 3'd7
    } state_t;

endpackage

// File: rtl/dut_poll_timer.sv
// Counts failed status polls within one wait state and flags the poll that
// reaches POLL_LIMIT.
module dut_poll_timer #(
    parameter int POLL_LIMIT = 64
) (
    input  logic CLK,
    input  logic RST,
    input  logic clear,
    input  logic fail,
    output logic limit_hit
);

    localparam int CW = $clog2(POLL_LIMIT + 1);

    logic [CW-1:0] poll_cnt;

    // The failing poll itself is the one that reaches the limit, so the hit is combinational.
    assign limit_hit = fail && (poll_cnt == CW'(POLL_LIMIT - 1));

    always_ff @(posedge CLK) begin
        if (RST || clear) begin
            poll_cnt <= '0;
        end else if (fail) begin
            poll_cnt <= poll_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/dut_txn_master.sv
// Bus master that pushes each (a,b) pair into the dut FIFOs, polls for the result
// and presents y on an output valid/ready stream.
module dut_txn_master
    import dut_txn_pkg::*;
#(
    parameter int POLL_LIMIT = 64
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_a,
    input  logic                 in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_y,
    output logic [2:0]           write_address,
    output logic                 write_data,
    output logic                 write_en,
    input  logic                 write_rdy,
    output logic [2:0]           read_address,
    output logic                 read_en,
    input  logic                 read_data,
    input  logic                 read_rdy,
    output logic                 err,
    output logic [TXN_CNT_W-1:0] txn_count
);

    state_t state, state_next;
    logic   a_reg, b_reg, y_reg;
    logic   is_chk, poll_fail, poll_clear, limit_hit;

    assign is_chk     = (state == ST_CHK_A) || (state == ST_CHK_B) || (state == ST_CHK_Y);
    assign poll_fail  = read_en && !read_data && is_chk;
    assign poll_clear = (state_next != state);
    assign out_y      = y_reg;

    dut_poll_timer #(.POLL_LIMIT(POLL_LIMIT)) u_poll_timer (
        .CLK       (CLK),
        .RST       (RST),
        .clear     (poll_clear),
        .fail      (poll_fail),
        .limit_hit (limit_hit)
    );

    // NOTE: every output gets a default before the case, so no path can infer a latch.
    always_comb begin
        in_ready      = 1'b0;
        out_valid     = 1'b0;
        write_address = 3'd0;
        write_data    = 1'b0;
        write_en      = 1'b0;
        read_address  = 3'd0;
        read_en       = 1'b0;
        case (state)
            ST_IDLE:  in_ready = 1'b1;
            ST_CHK_A: begin read_address = ADDR_A_ST; read_en = read_rdy; end
            ST_WR_A:  begin write_address = ADDR_A; write_data = a_reg; write_en = write_rdy; end
            ST_CHK_B: begin read_address = ADDR_B_ST; read_en = read_rdy; end
            ST_WR_B:  begin write_address = ADDR_B; write_data = b_reg; write_en = write_rdy; end
            ST_CHK_Y: begin read_address = ADDR_Y_ST; read_en = read_rdy; end
            ST_RD_Y:  begin read_address = ADDR_Y; read_en = read_rdy; end
            ST_OUT:   out_valid = 1'b1;
            default:  ;
        endcase
        // Strobes and handshakes stay low for the whole reset, not just after the edge.
        if (RST) begin
            in_ready  = 1'b0;
            out_valid = 1'b0;
            write_en  = 1'b0;
            read_en   = 1'b0;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (in_valid) state_next = ST_CHK_A;
            ST_CHK_A: if (read_en && read_data) state_next = ST_WR_A;
                      else if (limit_hit)       state_next = ST_IDLE;
            ST_WR_A:  if (write_en) state_next = ST_CHK_B;
            ST_CHK_B: if (read_en && read_data) state_next = ST_WR_B;
                      else if (limit_hit)       state_next = ST_IDLE;
            ST_WR_B:  if (write_en) state_next = ST_CHK_Y;
            ST_CHK_Y: if (read_en && read_data) state_next = ST_RD_Y;
                      else if (limit_hit)       state_next = ST_IDLE;
            ST_RD_Y:  if (read_en) state_next = ST_OUT;
            ST_OUT:   if (out_ready) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from
    // the same pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            // NOTE: operand registers are cleared too; cheap, and keeps write_data clean after reset.
            state     <= ST_IDLE;
            a_reg     <= 1'b0;
            b_reg     <= 1'b0;
            y_reg     <= 1'b0;
            err       <= 1'b0;
            txn_count <= '0;
        end else begin
            state <= state_next;
            if (state == ST_IDLE && in_valid) begin
                a_reg <= in_a;
                b_reg <= in_b;
            end
            if (state == ST_RD_Y && read_en) y_reg <= read_data;
            if (limit_hit) err <= 1'b1;
            if (state == ST_OUT && out_ready) txn_count <= txn_count + TXN_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_dut_txn_master.sv
// Self-checking bench for dut_txn_master: a behavioural dut responder plus a
// transaction-level model of the expected bus traffic, latency and counters.
module tb_dut_txn_master;

    localparam int LIMIT  = 4;
    localparam int BUDGET = 200;
    localparam int NEVER  = 100000;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        in_valid = 1'b0, in_a = 1'b0, in_b = 1'b0;
    logic        in_ready;
    logic        out_valid, out_y;
    logic        out_ready = 1'b0;
    logic [2:0]  write_address, read_address;
    logic        write_data, write_en, read_en;
    logic        write_rdy = 1'b1, read_rdy = 1'b1;
    logic        read_data;
    logic        err;
    logic [15:0] txn_count;

    always #5 CLK = ~CLK;

    dut_txn_master #(.POLL_LIMIT(LIMIT)) dut (
        .CLK(CLK), .RST(RST),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
        .write_address(write_address), .write_data(write_data), .write_en(write_en), .write_rdy(write_rdy),
        .read_address(read_address), .read_en(read_en), .read_data(read_data), .read_rdy(read_rdy),
        .err(err), .txn_count(txn_count)
    );

    int n_cmp = 0;
    int n_fail = 0;

    // Responder: status k answers 0 for st_fail[k] completed polls since base[k], then 1.
    int   rd_cnt[3] = '{0, 0, 0};
    int   base[3]   = '{0, 0, 0};
    int   st_fail[3] = '{0, 0, 0};
    logic y_val = 1'b0;

    logic [4:0] log_q[$];   // {is_write, address, data}
    logic [4:0] exp_q[$];

    logic        exp_err = 1'b0;
    logic [15:0] exp_cnt = 16'd0;

    always_comb begin
        read_data = 1'b0;
        case (read_address)
            3'd0: read_data = (rd_cnt[0] - base[0]) >= st_fail[0];
            3'd1: read_data = (rd_cnt[1] - base[1]) >= st_fail[1];
            3'd2: read_data = (rd_cnt[2] - base[2]) >= st_fail[2];
            3'd3: read_data = y_val;
            default: read_data = 1'b0;
        endcase
    end

    always @(posedge CLK) begin
        if (write_en && write_rdy) log_q.push_back({1'b1, write_address, write_data});
        if (read_en && read_rdy) begin
            log_q.push_back({1'b0, read_address, 1'b0});
            case (read_address)
                3'd0: rd_cnt[0] <= rd_cnt[0] + 1;
                3'd1: rd_cnt[1] <= rd_cnt[1] + 1;
                3'd2: rd_cnt[2] <= rd_cnt[2] + 1;
                default: ;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One wait state: min(f, LIMIT) failing polls, plus the successful one if f < LIMIT.
    task automatic add_polls(input logic [2:0] addr, input int f);
        int n;
        n = (f < LIMIT) ? f + 1 : LIMIT;
        repeat (n) exp_q.push_back({1'b0, addr, 1'b0});
    endtask

    task automatic build_exp(input logic a, input logic b, input int fa, input int fb, input int fy,
                             output logic done);
        exp_q.delete();
        done = 1'b0;
        add_polls(3'd0, fa);
        if (fa < LIMIT) begin
            exp_q.push_back({1'b1, 3'd4, a});
            add_polls(3'd1, fb);
            if (fb < LIMIT) begin
                exp_q.push_back({1'b1, 3'd5, b});
                add_polls(3'd2, fy);
                if (fy < LIMIT) begin
                    exp_q.push_back({1'b0, 3'd3, 1'b0});
                    done = 1'b1;
                end
            end
        end
    endtask

    task automatic arm_responder(input int fa, input int fb, input int fy, input logic yv);
        base       = rd_cnt;
        st_fail[0] = fa;
        st_fail[1] = fb;
        st_fail[2] = fy;
        y_val      = yv;
    endtask

    // Called on a negedge with the master idle; returns on a negedge with it idle again.
    task automatic run_txn(input logic a, input logic b, input int fa, input int fb, input int fy,
                           input logic yv, input logic stall, input int hold);
        logic done;
        int   k;
        int   lb;
        build_exp(a, b, fa, fb, fy, done);
        arm_responder(fa, fb, fy, yv);
        lb = log_q.size();
        in_a = a; in_b = b; in_valid = 1'b1;
        #1;
        check("in_ready_idle", in_ready, 1);
        @(posedge CLK); @(negedge CLK);
        in_valid = 1'b0; in_a = 1'b0; in_b = 1'b0;
        k = 0;
        while (!out_valid && !in_ready && k < BUDGET) begin
            if (stall) begin
                write_rdy = 1'($urandom_range(0, 1));
                read_rdy  = 1'($urandom_range(0, 1));
            end
            #1;
            check("strobe_rules", {(write_en && !write_rdy), (read_en && !read_rdy), (write_en && read_en)}, 0);
            @(posedge CLK); @(negedge CLK);
            k++;
        end
        write_rdy = 1'b1;
        read_rdy  = 1'b1;
        check("no_timeout", k < BUDGET, 1);
        check("out_valid_expected", out_valid, done);
        if (done) begin
            check("out_y", out_y, yv);
            check("err_on_result", err, exp_err);
            if (!stall) check("latency", k, 6 + fa + fb + fy);
            repeat (hold) begin
                check("hold_valid", out_valid, 1);
                check("hold_y", out_y, yv);
                check("hold_in_ready", in_ready, 0);
                check("hold_count", txn_count, exp_cnt);
                @(posedge CLK); @(negedge CLK);
            end
            out_ready = 1'b1;
            @(posedge CLK); @(negedge CLK);
            out_ready = 1'b0;
            exp_cnt++;
            check("count_after_hs", txn_count, exp_cnt);
            check("idle_after_hs", {in_ready, out_valid}, 2'b10);
        end else begin
            exp_err = 1'b1;
            check("err_after_abort", err, 1);
            check("idle_after_abort", {in_ready, out_valid}, 2'b10);
            check("count_after_abort", txn_count, exp_cnt);
        end
        check("log_len", log_q.size() - lb, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (lb + i < log_q.size()) check($sformatf("log_%0d", i), log_q[lb + i], exp_q[i]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset held over several edges
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_held_handshakes", {in_ready, out_valid, write_en, read_en}, 4'b0000);
        RST = 1'b0;
        #1;
        check("reset_err", err, 0);
        check("reset_count", txn_count, 0);
        check("reset_idle", {in_ready, out_valid, write_en, read_en}, 4'b1000);
        check("reset_y", out_y, 0);

        // Directed: minimum latency, polls with retries, output back-pressure, write stalls
        run_txn(1'b1, 1'b0, 0, 0, 0, 1'b1, 1'b0, 0);
        run_txn(1'b0, 1'b1, 3, 0, 0, 1'b0, 1'b0, 0);
        run_txn(1'b1, 1'b1, 0, 2, 1, 1'b1, 1'b0, 5);
        run_txn(1'b0, 1'b1, 1, 1, 1, 1'b1, 1'b1, 2);

        // Directed: Y status never ready -> timeout, sticky err
        run_txn(1'b1, 1'b0, 0, 0, NEVER, 1'b1, 1'b0, 0);
        run_txn(1'b1, 1'b1, 0, 0, 0, 1'b0, 1'b0, 0);

        // Randomized pairs, retry counts (LIMIT means timeout), stalls and hold-off
        for (int t = 0; t < 20; t++) begin
            run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    $urandom_range(0, LIMIT), $urandom_range(0, LIMIT), $urandom_range(0, LIMIT),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end

        // Reset in the middle of a Y-status wait
        arm_responder(0, 0, NEVER, 1'b0);
        in_a = 1'b1; in_b = 1'b1; in_valid = 1'b1;
        @(posedge CLK); @(negedge CLK);
        in_valid = 1'b0;
        repeat (6) begin @(posedge CLK); @(negedge CLK); end
        RST = 1'b1;
        #1;
        check("midrst_outputs", {in_ready, out_valid, write_en, read_en}, 4'b0000);
        @(posedge CLK); @(negedge CLK);
        check("midrst_held", {in_ready, out_valid, write_en, read_en}, 4'b0000);
        RST = 1'b0;
        #1;
        exp_err = 1'b0;
        exp_cnt = 16'd0;
        check("midrst_err", err, 0);
        check("midrst_count", txn_count, 0);
        check("midrst_idle", in_ready, 1);
        run_txn(1'b0, 1'b0, 0, 0, 0, 1'b1, 1'b0, 0);
        check("midrst_final_count", txn_count, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
